// File: rtl/alu_issue_unit.sv
// Issue unit for an external combinational ALU: holds operands stable for SETTLE_CYCLES,
// captures the result and flags into a 2-entry response FIFO, and flags illegal opcodes.
module alu_issue_unit #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [31:0] cmd_src1,
    input  logic [31:0] cmd_src2,
    output logic        alu_rst_n,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_cout,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_cout,
    output logic        rsp_overflow,
    output logic        rsp_err,
    output logic [15:0] op_count
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned SET_W   = 4;
    localparam int unsigned FCNT_W  = 2;
    localparam int unsigned OPCNT_W = 16;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              cout;
        logic              overflow;
        logic              err;
    } rsp_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_e;

    state_e             state_q;
    logic [SET_W-1:0]   settle_q;
    logic [DATA_W-1:0]  alu_src1_q;
    logic [DATA_W-1:0]  alu_src2_q;
    logic [OP_W-1:0]    alu_ctrl_q;
    logic               alu_rst_n_q;
    rsp_t               fifo_q [2];
    logic [FCNT_W-1:0]  fifo_cnt_q;
    logic [OPCNT_W-1:0] op_count_q;

    logic cmd_accept;
    logic op_legal;
    logic drive_done;
    logic push;
    logic pop;
    rsp_t push_entry;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0110,
            4'b0111, 4'b1001, 4'b1100, 4'b1101: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Handshake decode and the entry to push this cycle (ALU capture or error token)
    always_comb begin
        cmd_ready  = 1'b0;
        cmd_accept = 1'b0;
        op_legal   = 1'b0;
        drive_done = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        push_entry = '0;

        cmd_ready  = !rst_i && (state_q == IDLE) && (fifo_cnt_q < FCNT_W'(2));
        cmd_accept = cmd_valid && cmd_ready;
        op_legal   = op_is_legal(cmd_op);
        drive_done = (state_q == DRIVE) && (settle_q == SET_W'(0));
        push       = drive_done || (cmd_accept && !op_legal);
        pop        = (fifo_cnt_q != FCNT_W'(0)) && rsp_ready;

        if (drive_done) begin
            push_entry = '{result: alu_result, zero: alu_zero, cout: alu_cout,
                           overflow: alu_overflow, err: 1'b0};
        end else begin
            push_entry.err = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            settle_q    <= '0;
            alu_src1_q  <= '0;
            alu_src2_q  <= '0;
            alu_ctrl_q  <= '0;
            alu_rst_n_q <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            fifo_cnt_q  <= '0;
            op_count_q  <= '0;
        end else begin
            alu_rst_n_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (cmd_accept && op_legal) begin
                        alu_src1_q <= cmd_src1;
                        alu_src2_q <= cmd_src2;
                        alu_ctrl_q <= cmd_op;
                        settle_q   <= SET_W'(SETTLE_CYCLES - 1);
                        state_q    <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_q == SET_W'(0)) begin
                        state_q <= IDLE;
                    end else begin
                        settle_q <= settle_q - SET_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Shift-register FIFO: entry 0 is always the head
            case ({push, pop})
                2'b10: begin
                    fifo_q[fifo_cnt_q[0]] <= push_entry;
                    fifo_cnt_q            <= fifo_cnt_q + FCNT_W'(1);
                end
                2'b01: begin
                    fifo_q[0]  <= fifo_q[1];
                    fifo_cnt_q <= fifo_cnt_q - FCNT_W'(1);
                end
                2'b11: begin
                    if (fifo_cnt_q == FCNT_W'(1)) begin
                        fifo_q[0] <= push_entry;
                    end else begin
                        fifo_q[0] <= fifo_q[1];
                        fifo_q[1] <= push_entry;
                    end
                end
                default: ;
            endcase

            if (push) begin
                op_count_q <= op_count_q + OPCNT_W'(1);
            end
        end
    end

    assign alu_rst_n    = alu_rst_n_q;
    assign alu_src1     = alu_src1_q;
    assign alu_src2     = alu_src2_q;
    assign alu_ctrl     = alu_ctrl_q;
    assign rsp_valid    = (fifo_cnt_q != FCNT_W'(0));
    assign rsp_result   = fifo_q[0].result;
    assign rsp_zero     = fifo_q[0].zero;
    assign rsp_cout     = fifo_q[0].cout;
    assign rsp_overflow = fifo_q[0].overflow;
    assign rsp_err      = fifo_q[0].err;
    assign op_count     = op_count_q;

endmodule
